// File: rtl/matrix_stream_feeder_pkg.sv
// Shared types and constants for the matrix stream feeder: FSM states,
// operand beat lane positions and sizing helpers.
package matrix_stream_feeder_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_FEED    = 2'd1,
    S_COLLECT = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  // Lane positions inside a 4-lane operand beat (lane 3 sits in the MSBs)
  localparam int A_HI = 3;
  localparam int A_LO = 2;
  localparam int B_HI = 1;
  localparam int B_LO = 0;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int beat_count(input int mw);
    return (mw * mw) / 2;
  endfunction

endpackage

// File: rtl/matrix_stream_feeder_operand_bank.sv
// One square operand matrix: host write port plus a combinational read port
// returning the element pair at rows r and r+1 of column c.
module matrix_stream_feeder_operand_bank
  import matrix_stream_feeder_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int MATRIX_WIDTH = 4
) (
  input  logic                            i_clk,
  input  logic                            i_we,
  input  logic [idx_w(MATRIX_WIDTH)-1:0]  i_wr_row,
  input  logic [idx_w(MATRIX_WIDTH)-1:0]  i_wr_col,
  input  logic [WIDTH-1:0]                i_wr_data,
  input  logic [idx_w(MATRIX_WIDTH)-1:0]  i_rd_row,
  input  logic [idx_w(MATRIX_WIDTH)-1:0]  i_rd_col,
  output logic [2*WIDTH-1:0]              o_rd_pair
);

  localparam int IW = idx_w(MATRIX_WIDTH);

  logic [WIDTH-1:0] r_mem [MATRIX_WIDTH][MATRIX_WIDTH];
  logic [IW-1:0]    w_rd_row_lo;

  // Storage is deliberately left out of reset so operands survive an abort
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_wr_row][i_wr_col] <= i_wr_data;
    end
  end

  // The row index is always even while streaming, so r+1 never overflows
  assign w_rd_row_lo = i_rd_row + IW'(1);
  assign o_rd_pair   = {r_mem[i_rd_row][i_rd_col], r_mem[w_rd_row_lo][i_rd_col]};

endmodule

// File: rtl/matrix_stream_feeder.sv
// Loads operand matrices A and B from the host, streams them to the multiplier
// in column-major row-pair beats, then captures the result columns for readback.
module matrix_stream_feeder
  import matrix_stream_feeder_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int NUM_ELEMENTS = 4,
  parameter int MATRIX_WIDTH = 4,
  parameter int TIMEOUT      = 255
) (
  input  logic                           i_clk,
  input  logic                           i_reset,
  input  logic                           i_ld_en,
  input  logic                           i_ld_sel,
  input  logic [idx_w(MATRIX_WIDTH)-1:0] i_ld_row,
  input  logic [idx_w(MATRIX_WIDTH)-1:0] i_ld_col,
  input  logic [WIDTH-1:0]               i_ld_data,
  input  logic                           i_start,
  output logic [NUM_ELEMENTS*WIDTH-1:0]  o_rdata,
  output logic                           o_read_en,
  output logic                           o_write_en,
  input  logic [NUM_ELEMENTS*WIDTH-1:0]  i_res,
  input  logic                           i_write_ready,
  input  logic [idx_w(MATRIX_WIDTH)-1:0] i_rd_col,
  output logic [NUM_ELEMENTS*WIDTH-1:0]  o_rd_data,
  output logic                           o_busy,
  output logic                           o_done,
  output logic                           o_error
);

  localparam int IW         = idx_w(MATRIX_WIDTH);
  localparam int DW         = NUM_ELEMENTS * WIDTH;
  localparam int BEAT_COUNT = beat_count(MATRIX_WIDTH);
  localparam int BW         = idx_w(BEAT_COUNT + 1);
  localparam int WW         = idx_w(TIMEOUT);

  state_t        r_state, w_state_nxt;
  logic [IW-1:0] r_row, r_col, r_k;
  logic [IW-1:0] w_row_nxt, w_col_nxt, w_k_nxt;
  logic [BW-1:0] r_beat, w_beat_nxt;
  logic [WW-1:0] r_wdog, w_wdog_nxt;
  logic [DW-1:0] r_rdata, w_rdata_nxt;
  logic          r_read_en, w_read_en_nxt;
  logic          r_write_en, w_write_en_nxt;
  logic          r_done, w_done_nxt;
  logic          r_error, w_error_nxt;
  logic          w_clear, w_capture;
  logic [DW-1:0] r_res [MATRIX_WIDTH];

  logic              w_ld_ok, w_we_a, w_we_b, w_wrap;
  logic [IW-1:0]     w_addr_row, w_addr_col, w_adv_row, w_adv_col;
  logic [2*WIDTH-1:0] w_a_pair, w_b_pair;
  logic [DW-1:0]     w_beat;

  assign w_ld_ok = (r_state == S_IDLE) || (r_state == S_DONE);
  assign w_we_a  = i_ld_en && !i_ld_sel && w_ld_ok;
  assign w_we_b  = i_ld_en &&  i_ld_sel && w_ld_ok;

  // Beat 0 is issued on the start edge, so outside FEED the read address is (0,0)
  assign w_addr_row = (r_state == S_FEED) ? r_row : IW'(0);
  assign w_addr_col = (r_state == S_FEED) ? r_col : IW'(0);
  assign w_wrap     = (w_addr_row == IW'(MATRIX_WIDTH - 2));
  assign w_adv_row  = w_wrap ? IW'(0) : w_addr_row + IW'(2);
  assign w_adv_col  = w_wrap ? w_addr_col + IW'(1) : w_addr_col;

  matrix_stream_feeder_operand_bank #(.WIDTH(WIDTH), .MATRIX_WIDTH(MATRIX_WIDTH)) u_bank_a (
    .i_clk(i_clk), .i_we(w_we_a), .i_wr_row(i_ld_row), .i_wr_col(i_ld_col),
    .i_wr_data(i_ld_data), .i_rd_row(w_addr_row), .i_rd_col(w_addr_col), .o_rd_pair(w_a_pair)
  );

  matrix_stream_feeder_operand_bank #(.WIDTH(WIDTH), .MATRIX_WIDTH(MATRIX_WIDTH)) u_bank_b (
    .i_clk(i_clk), .i_we(w_we_b), .i_wr_row(i_ld_row), .i_wr_col(i_ld_col),
    .i_wr_data(i_ld_data), .i_rd_row(w_addr_row), .i_rd_col(w_addr_col), .o_rd_pair(w_b_pair)
  );

  assign w_beat[A_HI*WIDTH +: WIDTH] = w_a_pair[2*WIDTH-1 -: WIDTH];
  assign w_beat[A_LO*WIDTH +: WIDTH] = w_a_pair[WIDTH-1:0];
  assign w_beat[B_HI*WIDTH +: WIDTH] = w_b_pair[2*WIDTH-1 -: WIDTH];
  assign w_beat[B_LO*WIDTH +: WIDTH] = w_b_pair[WIDTH-1:0];

  // State register
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state, counter and registered-output decode
  always_comb begin
    w_state_nxt    = r_state;
    w_row_nxt      = r_row;
    w_col_nxt      = r_col;
    w_beat_nxt     = r_beat;
    w_k_nxt        = r_k;
    w_wdog_nxt     = r_wdog;
    w_rdata_nxt    = DW'(0);
    w_read_en_nxt  = 1'b0;
    w_write_en_nxt = 1'b0;
    w_done_nxt     = r_done;
    w_error_nxt    = r_error;
    w_clear        = 1'b0;
    w_capture      = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (i_start) begin
          w_state_nxt   = S_FEED;
          w_clear       = 1'b1;
          w_done_nxt    = 1'b0;
          w_error_nxt   = 1'b0;
          w_read_en_nxt = 1'b1;
          w_rdata_nxt   = w_beat;
          w_row_nxt     = w_adv_row;
          w_col_nxt     = w_adv_col;
          w_beat_nxt    = BW'(1);
          w_k_nxt       = IW'(0);
          w_wdog_nxt    = WW'(0);
        end else begin
          w_state_nxt = r_state;
        end
      end
      S_FEED: begin
        if (r_beat == BW'(BEAT_COUNT)) begin
          w_state_nxt    = S_COLLECT;
          w_write_en_nxt = 1'b1;
          w_row_nxt      = IW'(0);
          w_col_nxt      = IW'(0);
          w_beat_nxt     = BW'(0);
        end else begin
          w_read_en_nxt = 1'b1;
          w_rdata_nxt   = w_beat;
          w_row_nxt     = w_adv_row;
          w_col_nxt     = w_adv_col;
          w_beat_nxt    = r_beat + BW'(1);
        end
      end
      S_COLLECT: begin
        if (i_write_ready) begin
          w_capture  = 1'b1;
          w_k_nxt    = r_k + IW'(1);
          w_wdog_nxt = WW'(0);
          if (r_k == IW'(MATRIX_WIDTH - 1)) begin
            w_state_nxt = S_DONE;
            w_done_nxt  = 1'b1;
          end else begin
            w_write_en_nxt = 1'b1;
          end
        end else if (r_wdog == WW'(TIMEOUT - 1)) begin
          w_state_nxt = S_DONE;
          w_error_nxt = 1'b1;
        end else begin
          w_wdog_nxt     = r_wdog + WW'(1);
          w_write_en_nxt = 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Counters and registered outputs
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_row      <= IW'(0);
      r_col      <= IW'(0);
      r_k        <= IW'(0);
      r_beat     <= BW'(0);
      r_wdog     <= WW'(0);
      r_rdata    <= DW'(0);
      r_read_en  <= 1'b0;
      r_write_en <= 1'b0;
      r_done     <= 1'b0;
      r_error    <= 1'b0;
    end else begin
      r_row      <= w_row_nxt;
      r_col      <= w_col_nxt;
      r_k        <= w_k_nxt;
      r_beat     <= w_beat_nxt;
      r_wdog     <= w_wdog_nxt;
      r_rdata    <= w_rdata_nxt;
      r_read_en  <= w_read_en_nxt;
      r_write_en <= w_write_en_nxt;
      r_done     <= w_done_nxt;
      r_error    <= w_error_nxt;
    end
  end

  // Result buffer: wiped on reset and on every accepted start
  always_ff @(posedge i_clk) begin
    if (i_reset || w_clear) begin
      for (int i = 0; i < MATRIX_WIDTH; i++) begin
        r_res[i] <= DW'(0);
      end
    end else if (w_capture) begin
      r_res[r_k] <= i_res;
    end
  end

  assign o_rdata    = r_rdata;
  assign o_read_en  = r_read_en;
  assign o_write_en = r_write_en;
  assign o_done     = r_done;
  assign o_error    = r_error;
  assign o_busy     = (r_state == S_FEED) || (r_state == S_COLLECT);
  assign o_rd_data  = r_res[i_rd_col];

endmodule
